// File: rtl/rand_prefetch_pkg.sv
// Shared types for the RNG prefetcher: FTA bus command/response structs,
// FSM state encoding and responder register offsets.
package rand_prefetch_pkg;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] padr;
        logic [31:0] dat;
    } fta_cmd_request32_t;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } fta_cmd_response32_t;

    typedef enum logic [2:0] {IDLE, STRM, READ, ADV, GAP} state_t;

    localparam logic [3:0] RNG_REG_OUT    = 4'h0;
    localparam logic [3:0] RNG_REG_STREAM = 4'h4;

    // Full-word request with cyc/stb raised; the FSM holds it until ack.
    function automatic fta_cmd_request32_t bus_cmd(input logic        we,
                                                   input logic [31:0] padr,
                                                   input logic [31:0] dat);
        fta_cmd_request32_t c;
        c.cyc  = 1'b1;
        c.stb  = 1'b1;
        c.we   = we;
        c.sel  = 4'hF;
        c.padr = padr;
        c.dat  = dat;
        return c;
    endfunction

endpackage

// File: rtl/rand_prefetch_fifo.sv
// First-word-fall-through FIFO with registered head word and synchronous flush.
module rand_prefetch_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
)(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             push_dat_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [W-1:0]             dat_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_head;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [AW-1:0] w_rd_ptr_next;
    logic [W-1:0]  w_head_next;

    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == CW'(DEPTH));
    assign w_pop         = pop_i && !w_empty;
    assign w_push        = push_i && (!w_full || w_pop);
    assign w_rd_ptr_next = r_rd_ptr + AW'(w_pop);

    // Head bypasses the array when the incoming word becomes the new head.
    always_comb begin
        w_head_next = r_head;
        if (w_empty || (w_pop && r_count == CW'(1))) begin
            if (w_push)
                w_head_next = push_dat_i;
        end else if (w_pop) begin
            w_head_next = r_mem[w_rd_ptr_next];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wr_ptr] <= push_dat_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
            r_head   <= w_head_next;
        end
    end

    assign dat_o   = r_head;
    assign valid_o = !w_empty;
    assign count_o = r_count;

endmodule

// File: rtl/rand_prefetch_fta32.sv
// FTA-bus initiator that selects an RNG stream, then keeps a local FIFO topped up
// with READ/ADV pairs against the responder's output register.
module rand_prefetch_fta32
    import rand_prefetch_pkg::*;
#(
    parameter logic [31:0] RNG_ADDR   = 32'hFEE10000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          LOW_WATER  = 4,
    parameter int          TIMEOUT    = 255
)(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic [9:0]                    stream_i,
    input  logic                          stream_ld_i,
    output fta_cmd_request32_t            req,
    input  fta_cmd_response32_t           resp,
    input  logic                          rd_i,
    output logic [31:0]                   dat_o,
    output logic                          valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          busy_o,
    output logic                          tmo_o
);
    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int          TW          = $clog2(TIMEOUT + 1);
    localparam logic [31:0] ADDR_OUT    = RNG_ADDR + 32'(RNG_REG_OUT);
    localparam logic [31:0] ADDR_STREAM = RNG_ADDR + 32'(RNG_REG_STREAM);

    state_t             r_state;
    fta_cmd_request32_t r_req;
    logic [9:0]         r_stream;
    logic               r_strm_pend;
    logic               r_next_adv;
    logic               r_tmo;
    logic [TW-1:0]      r_tmo_cnt;

    logic               w_done;
    logic               w_abort;
    logic               w_push;
    logic               w_low;
    logic               w_room;

    assign w_done  = r_req.cyc && resp.ack && !resp.err;
    assign w_abort = r_req.cyc && (resp.err || (!resp.ack && r_tmo_cnt == TW'(TIMEOUT - 1)));
    // Data belonging to a stream that is about to be replaced is dropped.
    assign w_push  = (r_state == READ) && w_done && !stream_ld_i && !r_strm_pend;
    assign w_low   = (count_o <= CW'(LOW_WATER));
    assign w_room  = (count_o <  CW'(FIFO_DEPTH));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_req       <= '0;
            r_stream    <= '0;
            r_strm_pend <= 1'b1;
            r_next_adv  <= 1'b0;
            r_tmo       <= 1'b0;
            r_tmo_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (en_i && !r_tmo) begin
                        if (r_strm_pend) begin
                            r_req     <= bus_cmd(1'b1, ADDR_STREAM, {22'h0, r_stream});
                            r_tmo_cnt <= '0;
                            r_state   <= STRM;
                        end else if (w_low) begin
                            r_req     <= bus_cmd(1'b0, ADDR_OUT, 32'h0);
                            r_tmo_cnt <= '0;
                            r_state   <= READ;
                        end
                    end
                end
                STRM, READ, ADV: begin
                    if (w_abort) begin
                        r_req      <= '0;
                        r_tmo      <= 1'b1;
                        r_next_adv <= 1'b0;
                        r_state    <= IDLE;
                    end else if (w_done) begin
                        r_req      <= '0;
                        r_next_adv <= (r_state == READ);
                        if (r_state == STRM)
                            r_strm_pend <= 1'b0;
                        r_state    <= GAP;
                    end else begin
                        r_tmo_cnt  <= r_tmo_cnt + 1'b1;
                    end
                end
                GAP: begin
                    // A pending stream change supersedes the advance of the old stream.
                    if (r_strm_pend) begin
                        r_req      <= bus_cmd(1'b1, ADDR_STREAM, {22'h0, r_stream});
                        r_tmo_cnt  <= '0;
                        r_next_adv <= 1'b0;
                        r_state    <= STRM;
                    end else if (r_next_adv) begin
                        r_req      <= bus_cmd(1'b1, ADDR_OUT, 32'h0);
                        r_tmo_cnt  <= '0;
                        r_next_adv <= 1'b0;
                        r_state    <= ADV;
                    end else if (en_i && w_room) begin
                        r_req      <= bus_cmd(1'b0, ADDR_OUT, 32'h0);
                        r_tmo_cnt  <= '0;
                        r_state    <= READ;
                    end else begin
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (stream_ld_i) begin
                r_stream    <= stream_i;
                r_strm_pend <= 1'b1;
                r_tmo       <= 1'b0;
            end
        end
    end

    rand_prefetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (w_push),
        .push_dat_i (resp.dat),
        .pop_i      (rd_i),
        .flush_i    (stream_ld_i),
        .dat_o      (dat_o),
        .valid_o    (valid_o),
        .count_o    (count_o)
    );

    assign req    = r_req;
    assign busy_o = (r_state != IDLE);
    assign tmo_o  = r_tmo;

endmodule
